pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register for the RV32 core, generalising the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It carries an opaque payload with a valid/ready handshake, an optional 2-entry skid buffer, and a synchronous flush. After each flush it enforces a programmable input hold-off window. Each stage boundary instantiates one copy, with the stage's fields concatenated into `in_data`.

## Interface
- `DATA_W`, 32: payload width in bits (≥1).
- `SKID`, 1: 0 = single register, ready path combinational from `out_ready`; 1 = 2-entry skid, `in_ready` driven from state only.
- `FLUSH_HOLD`, 1: cycles `in_ready` is held low after a flush or reset (0..15).
- `CLEAR_DATA`, 1: 1 = flush/reset zero stored payload; 0 = payload left unchanged, only valid bits cleared.

- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear (hazard/branch kill).
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage accepts payload this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream consumes head this cycle.
- `out_data`  out  DATA_W  head payload (registered).
- `occupancy`  out  2  entries held: 0, 1, or 2 (2 only when SKID=1).

## Operation
- Accept = `in_valid & in_ready`. Emit = `out_valid & out_ready`. Order is strictly FIFO. No payload is duplicated or dropped except by flush.
- State:
  - main entry (`main_v`, `main_d`) drives `out_valid`/`out_data`.
  - skid entry (`skid_v`, `skid_d`), present only when SKID=1.
  - hold counter `hold_cnt` (4 bits).
- SKID=0:
  - `in_ready = (~main_v | out_ready) & (hold_cnt==0) & ~flush`.
  - On accept, `main_d <= in_data` and `main_v <= 1`.
  - On emit without accept, `main_v <= 0`.
- SKID=1:
  - `in_ready = ~skid_v & (hold_cnt==0) & ~flush`.
  - On emit with `skid_v`, skid moves to main.
  - Accept with main free or emitting goes to main; otherwise it goes to skid.
  - Accept and emit in the same cycle leave occupancy unchanged.
- Flush (`flush=1`, `reset=0`):
  - At the edge, `main_v`, `skid_v` <= 0 and `hold_cnt <= FLUSH_HOLD`.
  - Stored data <= 0 if CLEAR_DATA=1.
  - `in_ready` is 0 during the flush cycle, so nothing is accepted.
  - An emit in the flush cycle is a legal completed transfer.
- Hold: while `hold_cnt != 0`, `in_ready=0` and the counter decrements by 1 per cycle. Emit is unaffected (the stage is empty anyway).
- Flush during hold reloads `hold_cnt` to FLUSH_HOLD (no accumulation).
- Reset behaves identically to flush and has priority over flush and all handshakes.

## Timing
- Values after reset edge:
  - `out_valid=0`, `out_data=0` (CLEAR_DATA=1; unchanged if 0).
  - `occupancy=0`.
  - `in_ready=0` for FLUSH_HOLD cycles, then 1.
  - With FLUSH_HOLD=0, `in_ready=1` the cycle after reset deasserts.
- Latency: accept in cycle N gives `out_valid=1` with that payload in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready=1`, both modes.
- SKID=1 backpressure:
  - `out_ready` falls in cycle N: the beat accepted in N goes to skid.
  - `in_ready=0` from N+1.
  - `out_ready` rising in cycle M: `in_ready=1` in M+1.
- SKID=0: `in_ready` follows `out_ready` combinationally in the same cycle.
- `occupancy` always equals `main_v + skid_v`, and `skid_v=1` implies `main_v=1`.

## Test plan
- Reset and hold: FLUSH_HOLD=2, reset for 1 cycle, `in_valid=1` held.
  - `in_ready` is low for 2 cycles after the reset edge.
  - The first beat (`in_data=32'hA5A5_0001`) is accepted in cycle 3 and appears on `out_data` in cycle 4.
  - `out_valid=0` before that.
- Streaming: SKID=1, 8 beats of `0x10..0x17` with `out_ready=1`.
  - The outputs are `0x10..0x17` on consecutive cycles with no gaps.
  - `occupancy` stays at 1.
- Backpressure: SKID=1, `out_ready` drops during beat `0x22` and stays low 3 cycles.
  - `0x23` is captured in skid, `occupancy=2`, and `in_ready=0` the next cycle.
  - After release, the output order is `0x22, 0x23, 0x24` with no loss or duplicate.
- Flush with full skid: occupancy 2, `flush=1` for 1 cycle.
  - Next cycle: `out_valid=0`, `occupancy=0`, `out_data=0` (CLEAR_DATA=1).
  - `in_ready` is low for FLUSH_HOLD cycles.
  - The `in_data` offered in the flush cycle is never emitted.
- Simultaneous events: `reset` and `flush` together with `in_valid=1` and `out_ready=1`. The reset values hold, and nothing is accepted.
  - SKID=0 with `main_v=1`, `out_ready=1`, `in_valid=1`: emit and accept occur in the same cycle, and the new beat appears next cycle.
- Random: 10k cycles of random valid, ready, and flush (5% flush), in both SKID modes. A scoreboard checks FIFO order, flush discard, and `occupancy` consistency.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic inter-stage pipeline register with valid/ready handshake, an
//   optional 2-entry skid buffer, synchronous flush and a post-flush input
//   hold-off window.
//
// Parameters
//   DATA_W     payload width
//   SKID       0: single register, in_ready combinational from out_ready
//              1: 2-entry skid, in_ready from state only
//   FLUSH_HOLD cycles in_ready stays low after flush/reset (0..15)
//   CLEAR_DATA 1: flush/reset zero the stored payload
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   flush              synchronous clear of all stored entries
//   in_valid/in_ready  upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data registered head
//   occupancy          entries held (0..2)
module pipe_stage_skid #(
   parameter int DATA_W     = 32,
   parameter int SKID       = 1,
   parameter int FLUSH_HOLD = 1,
   parameter int CLEAR_DATA = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              main_v, skid_v;
   logic [DATA_W-1:0] main_d, skid_d;
   logic [3:0]        hold_cnt;
   logic              hold_zero, room, accept, emit;

   assign hold_zero = (hold_cnt == 4'd0);

   // Skid mode decides room from stored state alone, cutting the
   // out_ready -> in_ready combinational path.
   assign room = (SKID != 0) ? ~skid_v : (~main_v | out_ready);

   // Reset clears the stage like a flush, so it also closes the input
   // side; otherwise upstream could see a handshake that gets discarded.
   assign in_ready = room & hold_zero & ~flush & ~reset;

   assign accept = in_valid & in_ready;
   assign emit   = main_v & out_ready;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         main_v   <= 1'b0;
         skid_v   <= 1'b0;
         hold_cnt <= 4'(FLUSH_HOLD);
         if (CLEAR_DATA != 0) begin
            main_d <= '0;
            skid_d <= '0;
         end
      end else begin
         if (!hold_zero)
            hold_cnt <= hold_cnt - 4'd1;
         // in_ready is low whenever skid_v is set, so a skid->main move
         // never coincides with an accept.
         if ((SKID != 0) && emit && skid_v) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
         end else if (accept && (!main_v || emit)) begin
            main_d <= in_data;
            main_v <= 1'b1;
         end else if (accept) begin
            // Only reachable with SKID=1: main is held by backpressure.
            skid_d <= in_data;
            skid_v <= 1'b1;
         end else if (emit) begin
            main_v <= 1'b0;
         end
      end
   end

   assign out_valid = main_v;
   assign out_data  = main_d;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
   logic        clk = 1'b0;
   logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        rdy0, ov0, rdy1, ov1;
   logic [31:0] od0, od1;
   logic [1:0]  occ0, occ1;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(32), .SKID(0), .FLUSH_HOLD(2), .CLEAR_DATA(1)) u0 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
      .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
      .occupancy(occ0));

   pipe_stage_skid #(.DATA_W(32), .SKID(1), .FLUSH_HOLD(2), .CLEAR_DATA(1)) u1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
      .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .occupancy(occ1));

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model: one FIFO queue per DUT ----------
   logic [31:0] q0[$], q1[$];
   int          hold0 = 0, hold1 = 0;
   bit          armed = 0;

   // capacity-based room: 1 entry (or 1 being replaced) vs 2 entries
   function automatic logic mdl_rdy(int skid, int sz, int hold);
      return (hold == 0) && !flush && !reset &&
             (skid != 0 ? (sz < 2) : (sz == 0 || out_ready));
   endfunction

   initial forever begin
      logic a0, a1, e0, e1;
      @(posedge clk);
      a0 = in_valid && mdl_rdy(0, q0.size(), hold0);
      a1 = in_valid && mdl_rdy(1, q1.size(), hold1);
      e0 = (q0.size() > 0) && out_ready;
      e1 = (q1.size() > 0) && out_ready;
      if (reset) armed = 1;
      if (reset || flush) begin
         q0.delete(); q1.delete(); hold0 = 2; hold1 = 2;
      end else begin
         if (e0) void'(q0.pop_front());
         if (e1) void'(q1.pop_front());
         if (a0) q0.push_back(in_data);
         if (a1) q1.push_back(in_data);
         if (hold0 > 0) hold0--;
         if (hold1 > 0) hold1--;
      end
   end

   // compare process: every cycle, away from the active edge
   initial forever begin
      @(negedge clk);
      if (armed) begin
         chk("m0.in_ready", rdy0, mdl_rdy(0, q0.size(), hold0));
         chk("m0.out_valid", ov0, q0.size() > 0);
         chk("m0.occupancy", occ0, q0.size());
         if (q0.size() > 0) chk("m0.out_data", od0, q0[0]);
         chk("m1.in_ready", rdy1, mdl_rdy(1, q1.size(), hold1));
         chk("m1.out_valid", ov1, q1.size() > 0);
         chk("m1.occupancy", occ1, q1.size());
         if (q1.size() > 0) chk("m1.out_data", od1, q1[0]);
      end
   end

   // one cycle of stimulus; literal checks follow at posedge+2
   task automatic drive(input logic rst, fl, iv, input logic [31:0] d, input logic ordy);
      @(posedge clk);
      #1;
      reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
   endtask

   initial begin
      // ---- reset and hold-off ----
      drive(1, 0, 1, 32'hA5A5_0001, 1);
      for (int c = 1; c <= 2; c++) begin
         drive(0, 0, 1, 32'hA5A5_0001, 1);
         chk("hold.rdy0", rdy0, 0);
         chk("hold.rdy1", rdy1, 0);
         chk("hold.ov1", ov1, 0);
         chk("hold.occ1", occ1, 0);
         chk("hold.od1", od1, 0);
      end
      drive(0, 0, 1, 32'hA5A5_0001, 1);
      chk("first.rdy1", rdy1, 1);
      chk("first.rdy0", rdy0, 1);
      chk("first.ov1", ov1, 0);
      drive(0, 0, 0, 32'h0, 1);
      chk("first.ov1b", ov1, 1);
      chk("first.od1", od1, 32'hA5A5_0001);
      chk("first.od0", od0, 32'hA5A5_0001);
      drive(0, 0, 0, 32'h0, 1);

      // ---- streaming 0x10..0x17 ----
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, 32'h10 + k, 1);
         chk("stream.rdy1", rdy1, 1);
         if (k > 0) begin
            chk("stream.od1", od1, 32'h10 + k - 1);
            chk("stream.occ1", occ1, 1);
         end
      end
      drive(0, 0, 0, 32'h0, 1);
      chk("stream.last", od1, 32'h17);
      chk("stream.lastocc", occ1, 1);
      drive(0, 0, 0, 32'h0, 1);
      chk("stream.empty", ov1, 0);

      // ---- backpressure during 0x22 ----
      drive(0, 0, 1, 32'h20, 1);
      drive(0, 0, 1, 32'h21, 1);
      drive(0, 0, 1, 32'h22, 1);
      drive(0, 0, 1, 32'h23, 0);
      chk("bp.od_c3", od1, 32'h22);
      chk("bp.rdy_c3", rdy1, 1);
      chk("bp.rdy0_c3", rdy0, 0);
      drive(0, 0, 1, 32'h24, 0);
      chk("bp.rdy_c4", rdy1, 0);
      chk("bp.occ_c4", occ1, 2);
      chk("bp.od_c4", od1, 32'h22);
      drive(0, 0, 1, 32'h24, 0);
      chk("bp.rdy_c5", rdy1, 0);
      drive(0, 0, 1, 32'h24, 1);
      chk("bp.rdy_c6", rdy1, 0);
      chk("bp.od_c6", od1, 32'h22);
      drive(0, 0, 1, 32'h24, 1);
      chk("bp.od_c7", od1, 32'h23);
      chk("bp.rdy_c7", rdy1, 1);
      chk("bp.occ_c7", occ1, 1);
      drive(0, 0, 0, 32'h0, 1);
      chk("bp.od_c8", od1, 32'h24);
      drive(0, 0, 0, 32'h0, 1);
      chk("bp.empty", ov1, 0);

      // ---- flush with full skid ----
      drive(0, 0, 1, 32'h41, 0);
      drive(0, 0, 1, 32'h42, 0);
      chk("fl.occ1", occ1, 1);
      drive(0, 1, 1, 32'hDEAD, 0);
      chk("fl.occ2", occ1, 2);
      chk("fl.rdy_fl", rdy1, 0);
      drive(0, 0, 1, 32'hBEEF, 1);
      chk("fl.ov1", ov1, 0);
      chk("fl.occ", occ1, 0);
      chk("fl.od1", od1, 0);
      chk("fl.od0", od0, 0);
      chk("fl.rdy1a", rdy1, 0);
      drive(0, 0, 1, 32'hBEEF, 1);
      chk("fl.rdy1b", rdy1, 0);
      drive(0, 0, 1, 32'hBEEF, 1);
      chk("fl.rdy1c", rdy1, 1);
      drive(0, 0, 0, 32'h0, 1);
      chk("fl.next", od1, 32'hBEEF);

      // ---- reset + flush together with handshakes ----
      drive(0, 0, 1, 32'h51, 1);
      drive(1, 1, 1, 32'h52, 1);
      chk("rf.rdy0", rdy0, 0);
      chk("rf.rdy1", rdy1, 0);
      drive(0, 0, 1, 32'h53, 1);
      chk("rf.ov0", ov0, 0);
      chk("rf.ov1", ov1, 0);
      chk("rf.occ1", occ1, 0);
      chk("rf.od1", od1, 0);
      drive(0, 0, 1, 32'h53, 1);
      drive(0, 0, 1, 32'h53, 1);
      chk("rf.rdy0b", rdy0, 1);
      // SKID=0 emit + accept in the same cycle
      drive(0, 0, 1, 32'h61, 1);
      chk("s0.od", od0, 32'h53);
      chk("s0.rdy", rdy0, 1);
      drive(0, 0, 0, 32'h0, 1);
      chk("s0.next", od0, 32'h61);
      chk("s0.ov", ov0, 1);

      // ---- random traffic ----
      for (int c = 0; c < 10000; c++)
         drive($urandom_range(999) == 0, $urandom_range(99) < 5,
               $urandom_range(1), $urandom, $urandom_range(9) < 7);
      drive(0, 0, 0, 32'h0, 1);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
